// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcode constants, instruction formats, encoder
// error codes and the signed-range helper used by immediate packing.
package rv32_pkg;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_OPCODE   = 2'd3
  } err_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // True when v is representable as an n-bit two's-complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic signed [31:0] s;
    s = $signed(v) >>> (n - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Places a full 32-bit immediate into its instruction-word bit positions for
// the format implied by the opcode, and flags alignment/range/opcode errors.
module imm_pack
  import rv32_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:0] imm,
  output logic [31:0] bits,
  output fmt_e        fmt,
  output err_e        err
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    bits = '0;
    fmt  = FMT_X;
    err  = ERR_NONE;
    case (opcode)
      LUI, AUIPC: begin
        fmt         = FMT_U;
        bits[31:12] = imm[31:12];
        if (imm[11:0] != '0) err = ERR_MISALIGN;
      end
      JAL: begin
        fmt         = FMT_J;
        bits[31:12] = {imm[20], imm[10:1], imm[11], imm[19:12]};
        if (imm[0])                     err = ERR_MISALIGN;
        else if (!fits_signed(imm, 21)) err = ERR_RANGE;
      end
      BRANCH: begin
        fmt         = FMT_B;
        bits[31:25] = {imm[12], imm[10:5]};
        bits[11:7]  = {imm[4:1], imm[11]};
        if (imm[0])                     err = ERR_MISALIGN;
        else if (!fits_signed(imm, 13)) err = ERR_RANGE;
      end
      JALR, LOAD, OP_IMM: begin
        fmt         = FMT_I;
        bits[31:20] = imm[11:0];
        if (!fits_signed(imm, 12)) err = ERR_RANGE;
      end
      STORE: begin
        fmt         = FMT_S;
        bits[31:25] = imm[11:5];
        bits[11:7]  = imm[4:0];
        if (!fits_signed(imm, 12)) err = ERR_RANGE;
      end
      OP:      fmt = FMT_R;
      default: err = ERR_OPCODE;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields into instruction words through a two-stage
// pipeline and streams them into instruction memory at an incrementing address.
module inst_encoder
  import rv32_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              full
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic        ready_en;
  logic        s1_valid;
  fields_t     s1;
  logic        s2_free, s1_adv, accept;
  logic [31:0] imm_bits, word;
  fmt_e        fmt;
  err_e        err;

  // An error result leaves S2 in the cycle it appears, so only a stalled
  // write can hold S2 occupied.
  assign s2_free  = !mem_we || mem_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = ready_en && !full && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;

  imm_pack u_imm_pack (
    .opcode (s1.opcode),
    .imm    (s1.imm),
    .bits   (imm_bits),
    .fmt    (fmt),
    .err    (err)
  );

  always_comb begin
    word      = imm_bits;
    word[6:0] = s1.opcode;
    case (fmt)
      FMT_R: begin
        word[31:25] = s1.funct7;
        word[24:20] = s1.rs2;
        word[19:15] = s1.rs1;
        word[14:12] = s1.funct3;
        word[11:7]  = s1.rd;
      end
      FMT_I: begin
        word[19:15] = s1.rs1;
        word[14:12] = s1.funct3;
        word[11:7]  = s1.rd;
      end
      FMT_S, FMT_B: begin
        word[24:20] = s1.rs2;
        word[19:15] = s1.rs1;
        word[14:12] = s1.funct3;
      end
      FMT_U, FMT_J: word[11:7] = s1.rd;
      default: ;
    endcase
  end

  // NOTE: S1 payload is qualified by s1_valid, so it carries no reset and
  // only the control state below returns to known values.
  always_ff @(posedge clk) begin
    if (accept) s1 <= '{in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      s1_valid  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
      full      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (clr) begin
        s1_valid  <= 1'b0;
        mem_we    <= 1'b0;
        err_valid <= 1'b0;
        mem_addr  <= BASE;
        full      <= 1'b0;
      end else begin
        err_valid <= 1'b0;
        if (mem_we && mem_ready) begin
          mem_we   <= 1'b0;
          mem_addr <= mem_addr + 1'b1;
          if (mem_addr == '1) full <= 1'b1;
        end
        // A new word entering S2 overrides the clear of a completing write.
        if (s1_adv) begin
          if (err != ERR_NONE) begin
            err_valid <= 1'b1;
            err_code  <= err;
          end else begin
            mem_we    <= 1'b1;
            mem_wdata <= word;
          end
        end
        if (accept)      s1_valid <= 1'b1;
        else if (s1_adv) s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the immediate generator: takes decoded instruction fields plus a full 32-bit immediate and packs them into an RV32I instruction word.
- Range-checks the immediate for the instruction format.
- Streams accepted words into instruction memory at an auto-incrementing address.
- Used by the boot loader / self-test path to assemble programs into instruction memory before the core leaves reset.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after reset or clr.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous; address := BASE_ADDR, full := 0, pipeline flushed.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_opcode  in  7  opcode.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; R-type only.
- in_imm  in  32  immediate as the final sign-extended/shifted value.
- mem_we  out  1  write request; held until mem_ready.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  packed instruction.
- mem_ready  in  1  memory accepts the write this cycle.
- err_valid  out  1  one-cycle pulse; a bundle was rejected.
- err_code  out  2  1 = range, 2 = misaligned, 3 = unsupported opcode; valid with err_valid.
- full  out  1  memory capacity reached.

Behaviour:
- Reset values: in_ready = 0 during reset, 1 on the first cycle after it; mem_we = 0; mem_addr = BASE_ADDR; mem_wdata = 0; err_valid = 0; err_code = 0; full = 0.
- Pipeline: S1 captures fields on in_valid & in_ready. S2 (output register) holds the packed word and error result.
  - Latency from accept to mem_we: 2 cycles.
  - Throughput: 1 per cycle while mem_ready = 1.
- in_ready = !full & (!s1_valid | s1 can advance). S1 advances when S2 is empty or S2 completes this cycle. No combinational path from in_valid to in_ready.
- Packing:
  - LUI/AUIPC (0110111/0010111): inst[31:12] = imm[31:12]; imm[11:0] != 0 -> err 2.
  - JAL (1101111): imm[20|10:1|11|19:12] in inst[31:12]. imm[0] != 0 -> err 2; imm outside signed 21-bit -> err 1.
  - Branch (1100011): imm[12|10:5] in inst[31:25], imm[4:1|11] in inst[11:7]. imm[0] != 0 -> err 2; outside signed 13-bit -> err 1.
  - JALR/Load/OP-IMM (1100111/0000011/0010011): imm[11:0] in inst[31:20]; outside signed 12-bit -> err 1.
  - Store (0100011): imm[11:5] in inst[31:25], imm[4:0] in inst[11:7]; same range rule as I-type.
  - OP (0110011): funct7 in inst[31:25]; in_imm ignored.
  - Fields unused by a format are ignored, never checked.
  - Any other opcode -> err 3.
  - If misaligned and out of range together, report err 2.
- Error bundle:
  - err_valid pulses one cycle when it reaches S2.
  - No mem_we is issued and the address does not advance.
  - S2 is freed the same cycle.
- Write handshake:
  - mem_we, mem_addr and mem_wdata are stable while mem_we & !mem_ready.
  - On mem_we & mem_ready, the address increments.
- Full: a completed write to address 2^ADDR_W-1 wraps the address to 0 and sets full. While full, in_ready = 0; bundles already in S1 still drain to memory.
- clr has priority over a same-cycle accept or write completion; that bundle is dropped.
- rst_n low mid-transfer aborts immediately to reset values.

Decomposition:
- Shared package (rv32_pkg):
  - opcode constants: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - format enum: R, I, S, B, U, J.
  - err_code constants.
  - The immediate generator uses the same opcode constants.
- One combinational sub-module, imm_pack (opcode, imm -> packed immediate bits, err). Keeps the datapath separate from the handshake/address control in inst_encoder.

Test Plan:
- ADDI x1,x0,-1 (opcode 0010011, rd=1, f3=0, imm=0xFFFFFFFF) -> mem_we 2 cycles later, wdata 0xFFF00093, addr 0; next addr 1.
- LUI x5, imm=0x12345000 -> 0x123452B7. Repeat with imm=0x12345001 -> err_valid, err_code 2, no mem_we, addr unchanged.
- BEQ x1,x2,+8 -> 0x00208463; SW x2,4(x1) -> 0x0020A223; JAL x1,+2048 -> 0x001000EF. Sent back-to-back, written on consecutive cycles.
- ADDI imm=2048 -> err_code 1; opcode 1111111 -> err_code 3. Neither writes.
- Hold mem_ready = 0 for 3 cycles during a write:
  - mem_addr and mem_wdata are stable.
  - in_ready drops once S1 and S2 are both occupied.
  - No bundle is lost.
- ADDR_W = 2: after 4 writes the address wraps to 0, full = 1, in_ready = 0. Pulse clr -> full = 0, addr = BASE_ADDR, accepts again. Assert rst_n low mid-write -> all outputs return to reset values.
